// File: rtl/i2c_regfile_arbiter_if.sv
// i2c_regfile_arbiter_if: I2C, core, SRAM and error-flag signals of the register-file arbiter
interface i2c_regfile_arbiter_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
);
  logic              i2c_xfc_write;
  logic              i2c_op;
  logic [ADDR_W-1:0] i2c_wraddr;
  logic [DATA_W-1:0] i2c_wdata;
  logic [DATA_W-1:0] i2c_rdata;
  logic              i2c_xfc_read;
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic [DATA_W-1:0] core_rdata;
  logic              core_rvalid;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              err_clr;
  logic              i2c_ovf;
  logic              i2c_wp_err;
  modport slave (
    input  i2c_xfc_write, i2c_op, i2c_wraddr, i2c_wdata, core_req, core_we, core_addr, core_wdata,
           mem_rdata, err_clr,
    output i2c_rdata, i2c_xfc_read, core_gnt, core_rdata, core_rvalid, mem_en, mem_we, mem_addr,
           mem_wdata, i2c_ovf, i2c_wp_err
  );
  modport master (
    output i2c_xfc_write, i2c_op, i2c_wraddr, i2c_wdata, core_req, core_we, core_addr, core_wdata,
           mem_rdata, err_clr,
    input  i2c_rdata, i2c_xfc_read, core_gnt, core_rdata, core_rvalid, mem_en, mem_we, mem_addr,
           mem_wdata, i2c_ovf, i2c_wp_err
  );
endinterface

// File: rtl/i2c_regfile_arbiter.sv
// i2c_regfile_arbiter: shares the register-file SRAM between the I2C path (priority, one-deep buffer) and the core
module i2c_regfile_arbiter #(
  parameter int                ADDR_W  = 11,
  parameter int                DATA_W  = 8,
  parameter logic [ADDR_W-1:0] WP_BASE = 11'h700
) (
  input logic                  clk,
  input logic                  reset,
  i2c_regfile_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACC, RDW} state_t;
  state_t            state_q, state_d;
  logic              pend_valid_q, pend_valid_d, pend_op_q, pend_load;
  logic [ADDR_W-1:0] pend_addr_q, go_addr, mem_addr_q;
  logic [DATA_W-1:0] pend_data_q, go_wdata, mem_wdata_q, i2c_rdata_q, core_rdata_q;
  logic              go, go_core, go_we, wp_hit, new_stb, busy, ovf_set, rd_done;
  logic              mem_en_q, mem_we_q, owner_q, core_gnt_q, i2c_xfc_read_q, core_rvalid_q;
  logic              ovf_q, wp_q;
  assign wp_hit  = bus.i2c_xfc_write && !bus.i2c_op && bus.i2c_wraddr >= WP_BASE;
  assign new_stb = bus.i2c_xfc_write && !wp_hit;
  assign busy    = state_q != IDLE;
  assign rd_done = state_q == RDW;
  // Issue selection (pending, new strobe, core) and pending-slot bookkeeping
  always_comb begin
    state_d      = state_q;
    go           = 1'b0;
    go_core      = 1'b0;
    go_we        = 1'b0;
    go_addr      = bus.core_addr;
    go_wdata     = bus.core_wdata;
    ovf_set      = new_stb && busy && pend_valid_q;
    pend_load    = new_stb && (busy || pend_valid_q) && !ovf_set;
    pend_valid_d = pend_valid_q || pend_load;
    case (state_q)
      IDLE: begin
        if (pend_valid_q) begin
          go           = 1'b1;
          go_we        = !pend_op_q;
          go_addr      = pend_addr_q;
          go_wdata     = pend_data_q;
          pend_valid_d = pend_load;
        end else if (new_stb) begin
          go       = 1'b1;
          go_we    = !bus.i2c_op;
          go_addr  = bus.i2c_wraddr;
          go_wdata = bus.i2c_wdata;
        end else if (bus.core_req) begin
          go      = 1'b1;
          go_core = 1'b1;
          go_we   = bus.core_we;
        end
        state_d = go ? ACC : IDLE;
      end
      ACC:     state_d = mem_we_q ? IDLE : RDW;
      default: state_d = IDLE;
    endcase
  end
  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end
  // One-deep I2C pending slot
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_valid_q <= 1'b0;
      pend_op_q    <= 1'b0;
      pend_addr_q  <= '0;
      pend_data_q  <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      if (pend_load) begin
        pend_op_q   <= bus.i2c_op;
        pend_addr_q <= bus.i2c_wraddr;
        pend_data_q <= bus.i2c_wdata;
      end
    end
  end
  // Registered SRAM command, core grant and access owner
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      owner_q     <= 1'b0;
      core_gnt_q  <= 1'b0;
    end else begin
      mem_en_q   <= go;
      mem_we_q   <= go && go_we;
      core_gnt_q <= go && go_core;
      if (go) begin
        mem_addr_q  <= go_addr;
        mem_wdata_q <= go_wdata;
        owner_q     <= go_core;
      end
    end
  end
  // Read data capture in RDW, routed to the access owner
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i2c_xfc_read_q <= 1'b0;
      core_rvalid_q  <= 1'b0;
      i2c_rdata_q    <= '0;
      core_rdata_q   <= '0;
    end else begin
      i2c_xfc_read_q <= rd_done && !owner_q;
      core_rvalid_q  <= rd_done && owner_q;
      if (rd_done && !owner_q) i2c_rdata_q <= bus.mem_rdata;
      if (rd_done && owner_q)  core_rdata_q <= bus.mem_rdata;
    end
  end
  // Sticky error flags; a set wins over a simultaneous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
      wp_q  <= 1'b0;
    end else begin
      ovf_q <= ovf_set || (ovf_q && !bus.err_clr);
      wp_q  <= wp_hit || (wp_q && !bus.err_clr);
    end
  end
  assign bus.mem_en       = mem_en_q;
  assign bus.mem_we       = mem_we_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;
  assign bus.core_gnt     = core_gnt_q;
  assign bus.i2c_xfc_read = i2c_xfc_read_q;
  assign bus.i2c_rdata    = i2c_rdata_q;
  assign bus.core_rvalid  = core_rvalid_q;
  assign bus.core_rdata   = core_rdata_q;
  assign bus.i2c_ovf      = ovf_q;
  assign bus.i2c_wp_err   = wp_q;
endmodule

// File: tb/tb_i2c_regfile_arbiter.sv
// tb_i2c_regfile_arbiter: directed stimulus with a queue-based scoreboard for the register-file arbiter
module tb_i2c_regfile_arbiter;
  typedef struct {int c; logic we; logic [10:0] a; logic [7:0] d;} mexp_t;
  typedef struct {int c; logic [7:0] d;} rexp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int errors = 0;
  int checks = 0;
  mexp_t mq[$];
  rexp_t iq[$];
  rexp_t cq[$];
  int gq[$];
  logic [7:0] sram [0:2047];

  i2c_regfile_arbiter_if bus();
  i2c_regfile_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.mem_en && !bus.mem_we) bus.mem_rdata <= sram[bus.mem_addr];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: unexpected pulse at cycle %0d", nm, cyc);
  endtask

  // Scoreboard monitor: pops an expectation whenever the DUT presents an event
  always @(negedge clk) if (reset) begin
    if (bus.mem_en) begin
      if (mq.size() == 0) unexpected("mem_en");
      else begin
        mexp_t m;
        m = mq.pop_front();
        chk("mem access cyc/we/addr/wdata",
            {cyc, bus.mem_we, bus.mem_addr, bus.mem_we ? bus.mem_wdata : 8'h00},
            {m.c, m.we, m.a, m.we ? m.d : 8'h00});
      end
    end
    if (bus.i2c_xfc_read) begin
      if (iq.size() == 0) unexpected("i2c_xfc_read");
      else begin
        rexp_t r;
        r = iq.pop_front();
        chk("i2c read cyc/data", {cyc, bus.i2c_rdata}, {r.c, r.d});
      end
    end
    if (bus.core_rvalid) begin
      if (cq.size() == 0) unexpected("core_rvalid");
      else begin
        rexp_t r;
        r = cq.pop_front();
        chk("core read cyc/data", {cyc, bus.core_rdata}, {r.c, r.d});
      end
    end
    if (bus.core_gnt) begin
      if (gq.size() == 0) unexpected("core_gnt");
      else chk("core_gnt cyc", cyc, gq.pop_front());
    end
  end

  task automatic i2c(input logic op, input logic [10:0] a, input logic [7:0] d);
    bus.i2c_xfc_write = 1'b1;
    bus.i2c_op = op;
    bus.i2c_wraddr = a;
    bus.i2c_wdata = d;
  endtask

  task automatic core(input logic we, input logic [10:0] a, input logic [7:0] d);
    bus.core_req = 1'b1;
    bus.core_we = we;
    bus.core_addr = a;
    bus.core_wdata = d;
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [63:0] outs();
    return {bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.i2c_rdata, bus.i2c_xfc_read,
            bus.core_gnt, bus.core_rdata, bus.core_rvalid, bus.i2c_ovf, bus.i2c_wp_err};
  endfunction

  initial begin
    int t;
    bus.i2c_xfc_write = 0; bus.i2c_op = 0; bus.i2c_wraddr = 0; bus.i2c_wdata = 0;
    bus.core_req = 0; bus.core_we = 0; bus.core_addr = 0; bus.core_wdata = 0; bus.err_clr = 0;
    sram[11'h010] = 8'h3C; sram[11'h020] = 8'h5A; sram[11'h040] = 8'h11; sram[11'h700] = 8'h99;
    #3 reset = 1'b0;
    #1 chk("outputs in reset", outs(), 64'h0);
    @(negedge clk) reset = 1'b1;
    wait_n(2);
    chk("flags after reset", {bus.i2c_ovf, bus.i2c_wp_err}, 2'b00);
    // I2C write A5 -> 010
    t = cyc; i2c(0, 11'h010, 8'hA5);
    mq.push_back('{t + 1, 1'b1, 11'h010, 8'hA5});
    @(negedge clk) bus.i2c_xfc_write = 0;
    wait_n(4);
    // I2C read of 010, SRAM returns 3C
    t = cyc; i2c(1, 11'h010, 8'h00);
    mq.push_back('{t + 1, 1'b0, 11'h010, 8'h00});
    iq.push_back('{t + 3, 8'h3C});
    @(negedge clk) bus.i2c_xfc_write = 0;
    wait_n(4);
    // Core read with an I2C write arriving in its ACC cycle
    t = cyc; core(0, 11'h020, 8'h00);
    mq.push_back('{t + 1, 1'b0, 11'h020, 8'h00});
    gq.push_back(t + 1);
    cq.push_back('{t + 3, 8'h5A});
    mq.push_back('{t + 4, 1'b1, 11'h030, 8'h77});
    @(negedge clk) begin bus.core_req = 0; i2c(0, 11'h030, 8'h77); end
    @(negedge clk) bus.i2c_xfc_write = 0;
    wait_n(6);
    // Core read, then three back-to-back I2C writes: first runs, second waits, third overflows
    t = cyc; core(0, 11'h040, 8'h00);
    mq.push_back('{t + 1, 1'b0, 11'h040, 8'h00});
    gq.push_back(t + 1);
    cq.push_back('{t + 3, 8'h11});
    @(negedge clk) bus.core_req = 0;
    @(negedge clk) i2c(0, 11'h050, 8'h01);
    mq.push_back('{t + 4, 1'b1, 11'h050, 8'h01});
    @(negedge clk) i2c(0, 11'h051, 8'h02);
    mq.push_back('{t + 6, 1'b1, 11'h051, 8'h02});
    @(negedge clk) i2c(0, 11'h052, 8'h03);
    @(negedge clk) bus.i2c_xfc_write = 0;
    chk("i2c_ovf set", bus.i2c_ovf, 1'b1);
    wait_n(3);
    bus.err_clr = 1;
    @(negedge clk) bus.err_clr = 0;
    chk("i2c_ovf cleared / wp clear", {bus.i2c_ovf, bus.i2c_wp_err}, 2'b00);
    wait_n(2);
    // Write-protect window: 700 dropped, 6FF allowed, read of 700 allowed, core write 7FF allowed
    i2c(0, 11'h700, 8'hFF);
    @(negedge clk) bus.i2c_xfc_write = 0;
    chk("i2c_wp_err set", bus.i2c_wp_err, 1'b1);
    wait_n(2);
    t = cyc; i2c(0, 11'h6FF, 8'hA1);
    mq.push_back('{t + 1, 1'b1, 11'h6FF, 8'hA1});
    @(negedge clk) bus.i2c_xfc_write = 0;
    wait_n(3);
    t = cyc; i2c(1, 11'h700, 8'h00);
    mq.push_back('{t + 1, 1'b0, 11'h700, 8'h00});
    iq.push_back('{t + 3, 8'h99});
    @(negedge clk) bus.i2c_xfc_write = 0;
    wait_n(4);
    t = cyc; core(1, 11'h7FF, 8'h42);
    mq.push_back('{t + 1, 1'b1, 11'h7FF, 8'h42});
    gq.push_back(t + 1);
    @(negedge clk) bus.core_req = 0;
    wait_n(3);
    // Set and clear in the same cycle: set wins
    bus.err_clr = 1; i2c(0, 11'h7AB, 8'h5E);
    @(negedge clk) begin bus.err_clr = 0; bus.i2c_xfc_write = 0; end
    chk("wp_err set beats clear", bus.i2c_wp_err, 1'b1);
    bus.err_clr = 1;
    @(negedge clk) bus.err_clr = 0;
    chk("wp_err cleared", bus.i2c_wp_err, 1'b0);
    wait_n(2);
    // Reset during RDW of an I2C read: no read pulse afterwards
    t = cyc; i2c(1, 11'h010, 8'h00);
    mq.push_back('{t + 1, 1'b0, 11'h010, 8'h00});
    @(negedge clk) bus.i2c_xfc_write = 0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("outputs on reset in RDW", outs(), 64'h0);
    wait_n(3);
    reset = 1'b1;
    wait_n(6);
    chk("leftover mem expectations", mq.size(), 0);
    chk("leftover i2c read expectations", iq.size(), 0);
    chk("leftover core read expectations", cq.size(), 0);
    chk("leftover core_gnt expectations", gq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
